// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack: operation encoding and width helpers.
package stack_pkg;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } op_e;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Push together with pop on an empty stack degrades to a plain push.
  function automatic op_e decode_op(input logic push, input logic pop, input logic empty);
    if (push && pop && !empty) return OP_REPLACE;
    if (push)                  return OP_PUSH;
    if (pop)                   return OP_POP;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module stack_ram
  import stack_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack with internal pointer, replace-top, flush and sticky overflow/underflow flags.
module lifo_stack
  import stack_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = addr_w(DEPTH),
  localparam int CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  logic [CNT_W-1:0]  sp_q, sp_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  op_e               op;

  assign empty = (sp_q == '0);
  assign full  = (sp_q == CNT_W'(DEPTH));
  assign op    = decode_op(push, pop, empty);
  assign raddr = ADDR_W'(sp_q - CNT_W'(1));

  always_comb begin
    sp_d        = sp_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    we          = 1'b0;
    waddr       = sp_q[ADDR_W-1:0];
    unique case (op)
      OP_PUSH: begin
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          we   = 1'b1;
          sp_d = sp_q + CNT_W'(1);
        end
      end
      OP_POP: begin
        if (empty) begin
          underflow_d = 1'b1;
        end else begin
          sp_d = sp_q - CNT_W'(1);
        end
      end
      OP_REPLACE: begin
        we    = 1'b1;
        waddr = raddr;
      end
      default: ;
    endcase
    // A flush discards any concurrent request, including its RAM write.
    if (rst || clear) begin
      sp_d        = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      we          = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (din),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign top       = empty ? '0 : rdata;
  assign count     = sp_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_lifo_stack.sv
// Bench for lifo_stack: queue-based reference model checked every cycle, plus directed literals.
module tb_lifo_stack;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic [DATA_W-1:0] top_o;
  logic [CNT_W-1:0]  count_o;
  logic              empty_o, full_o, overflow_o, underflow_o;

  int tests_run = 0;
  int tests_failed = 0;
  bit chk_en = 1'b0;

  logic [DATA_W-1:0] model_q[$];
  bit                m_ovf = 1'b0;
  bit                m_unf = 1'b0;

  always #5 clk = ~clk;

  lifo_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .din       (din),
    .top       (top_o),
    .count     (count_o),
    .empty     (empty_o),
    .full      (full_o),
    .overflow  (overflow_o),
    .underflow (underflow_o)
  );

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] m_top();
    return (model_q.size() == 0) ? '0 : model_q[$];
  endfunction

  // Reference: the stack is a queue whose back is the top.
  task automatic model_update(input bit r, input bit c, input bit ps, input bit pp, input logic [DATA_W-1:0] d);
    if (r || c) begin
      model_q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (ps && pp) begin
      if (model_q.size() == 0) model_q.push_back(d);
      else model_q[model_q.size()-1] = d;
    end else if (ps) begin
      if (model_q.size() == DEPTH) m_ovf = 1;
      else model_q.push_back(d);
    end else if (pp) begin
      if (model_q.size() == 0) m_unf = 1;
      else void'(model_q.pop_back());
    end
  endtask

  // Inputs are set away from the edge, sampled at posedge, model advanced right after.
  task automatic step(input bit r, input bit c, input bit ps, input bit pp, input logic [DATA_W-1:0] d);
    rst = r; clear = c; push = ps; pop = pp; din = d;
    @(posedge clk);
    model_update(r, c, ps, pp, d);
    #1;
    rst = 0; clear = 0; push = 0; pop = 0;
    $display("[TB] rst=%0b clr=%0b push=%0b pop=%0b din=%08h -> count=%0d top=%08h ovf=%0b unf=%0b",
             r, c, ps, pp, d, count_o, top_o, overflow_o, underflow_o);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",     DATA_W'(count_o),  DATA_W'(model_q.size()));
      chk("top",       top_o,             m_top());
      chk("empty",     DATA_W'(empty_o),  DATA_W'(model_q.size() == 0));
      chk("full",      DATA_W'(full_o),   DATA_W'(model_q.size() == DEPTH));
      chk("overflow",  DATA_W'(overflow_o),  DATA_W'(m_ovf));
      chk("underflow", DATA_W'(underflow_o), DATA_W'(m_unf));
    end
  end

  task automatic chk_state(input string tag, input int cnt, input logic [DATA_W-1:0] tp,
                           input bit ovf, input bit unf);
    chk({tag, ".count"}, DATA_W'(count_o), DATA_W'(cnt));
    chk({tag, ".top"},   top_o, tp);
    chk({tag, ".empty"}, DATA_W'(empty_o), DATA_W'(cnt == 0));
    chk({tag, ".full"},  DATA_W'(full_o),  DATA_W'(cnt == DEPTH));
    chk({tag, ".ovf"},   DATA_W'(overflow_o), DATA_W'(ovf));
    chk({tag, ".unf"},   DATA_W'(underflow_o), DATA_W'(unf));
    chk({tag, ".model_top"}, m_top(), tp);
  endtask

  task automatic flush_with(input bit use_rst, input string tag);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, 32'h60 + i);
    step(0, 0, 1, 0, 32'h99);
    step(0, 0, 0, 1, 0);
    chk_state({tag, "_pre"}, 3, 32'h62, 1, 1);
    step(use_rst, !use_rst, 1, 0, 32'h77);
    chk_state(tag, 0, 32'h0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    step(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    chk_state("reset", 0, 32'h0, 0, 0);

    step(0, 0, 1, 0, 32'h11); chk_state("push1", 1, 32'h11, 0, 0);
    step(0, 0, 1, 0, 32'h22); chk_state("push2", 2, 32'h22, 0, 0);
    step(0, 0, 1, 0, 32'h33); chk_state("push3", 3, 32'h33, 0, 0);
    step(0, 0, 1, 0, 32'h44); chk_state("push4", 4, 32'h44, 0, 0);
    step(0, 0, 1, 0, 32'h55); chk_state("ovf",   4, 32'h44, 1, 0);
    step(0, 0, 0, 1, 0); chk_state("pop1", 3, 32'h33, 1, 0);
    step(0, 0, 0, 1, 0); chk_state("pop2", 2, 32'h22, 1, 0);
    step(0, 0, 0, 1, 0); chk_state("pop3", 1, 32'h11, 1, 0);
    step(0, 0, 0, 1, 0); chk_state("pop4", 0, 32'h0,  1, 0);
    step(0, 0, 0, 1, 0); chk_state("unf",  0, 32'h0,  1, 1);

    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 32'h11);
    step(0, 0, 1, 0, 32'h22);
    step(0, 0, 1, 1, 32'hAA); chk_state("replace", 2, 32'hAA, 0, 0);
    step(0, 0, 0, 1, 0);      chk_state("rep_pop", 1, 32'h11, 0, 0);

    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 32'h5A); chk_state("pp_empty", 1, 32'h5A, 0, 0);

    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 32'hC0 + i);
    step(0, 0, 1, 1, 32'hF0); chk_state("rep_full", 4, 32'hF0, 0, 0);

    flush_with(0, "clear");
    flush_with(1, "rst");

    for (int n = 0; n < 3000; n++) begin
      int sel;
      bit r, c, ps, pp;
      sel = $urandom_range(0, 255);
      r  = (sel == 0);
      c  = (sel inside {[1:3]});
      ps = ($urandom_range(0, 99) < 55);
      pp = ($urandom_range(0, 99) < 45);
      step(r, c, ps, pp, $urandom);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
# lifo_stack

Parametrised LIFO stack built on an internal word-addressed RAM. It is the next generation of the team's 32×32 switch-addressed RAM block. Instead of exposing raw addresses, it manages a stack pointer internally and provides push, pop, replace-top and clear operations. It reports occupancy, full/empty status and sticky overflow/underflow errors, and sits between board-level switch/LED glue and the memory array.

## Interface
- DATA_W, 32, word width in bits (≥1)
- DEPTH, 32, number of stack entries (≥2)
- ADDR_W, $clog2(DEPTH), derived; stack-pointer/RAM address width
- CNT_W, $clog2(DEPTH+1), derived; occupancy counter width

- clk  in  1  single system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous stack flush, same effect as rst on control state
- push  in  1  write din onto stack this cycle
- pop  in  1  remove top entry this cycle
- din  in  DATA_W  data to push / replace
- top  out  DATA_W  current top-of-stack word; 0 when empty
- count  out  CNT_W  number of valid entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty

## Operation
- State: register sp (CNT_W bits, 0..DEPTH) equals count. RAM `mem[0..DEPTH-1]`; entry sp-1 is the top.
- Priority per cycle: rst > clear > push/pop.
- rst or clear: sp←0; overflow←0; underflow←0. RAM contents are not cleared; they are unobservable while empty.
- push only, not full: mem[sp]←din; sp←sp+1.
- push only, full: no RAM write, sp unchanged, overflow←1.
- pop only, not empty: sp←sp-1. Popped data is not returned; it was visible on top before the edge.
- pop only, empty: sp unchanged, underflow←1.
- push and pop, not empty: replace top. mem[sp-1]←din; sp unchanged; valid even when full; no error flag.
- push and pop, empty: treated as plain push (mem[0]←din, sp←1); underflow not set.
- Neither push nor pop: hold.
- Error flags set only by the listed events. They are cleared only by rst/clear.
- Arithmetic: sp never wraps. Guarded ops make sp+1 > DEPTH and sp-1 < 0 unreachable.
- top = empty ? 0 : mem[sp-1], read asynchronously from the current sp and mem.

## Timing
- Reset values: top=0, count=0, empty=1, full=0, overflow=0, underflow=0.
- All outputs reflect the post-edge state. After a push/pop/replace at edge N, top/count/flags are valid in the cycle following edge N. There is no additional latency.
- push/pop are level-sampled per edge. Holding push high for k cycles performs k pushes, up to full.
- overflow/underflow rise at the edge where the offending request is sampled.
- Reset mid-sequence: stack empty on the next cycle regardless of concurrent push/pop. A push in the rst cycle is discarded.
- No handshake: requests are never stalled. Refused operations are signalled only through the sticky flags.

## Structure
- Shared package `stack_pkg`: op encoding enum {OP_NONE, OP_PUSH, OP_POP, OP_REPLACE} derived from {push,pop,empty}, plus the CNT_W/ADDR_W helper functions.
- Sub-module `stack_ram`: DEPTH×DATA_W, one synchronous write port (we, waddr, wdata), one asynchronous read port (raddr, rdata).
- `lifo_stack` holds sp, error flags, op decode and the top-zeroing mux.

## Test plan
All scenarios use DATA_W=32, DEPTH=4.
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles → count 1, 2, 3; top 0x11, 0x22, 0x33; empty=0, full=0.
- Push 0x44 → full=1, count=4, top=0x44. Push 0x55 → overflow=1, top=0x44, count=4.
- Pop four times → top 0x33, 0x22, 0x11, 0; empty=1. Fifth pop → underflow=1, count=0.
- From stack {0x11,0x22}, assert push and pop with din=0xAA → count=2, top=0xAA. One pop → top=0x11.
- Push and pop asserted on empty with din=0x5A → count=1, top=0x5A, underflow=0.
- Set both error flags, fill the stack to 3 entries, assert clear together with push → next cycle count=0, empty=1, top=0, overflow=0, underflow=0. Repeat using rst, same result.
